// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: MMIO map, TX_STATUS layout,
// address regions and the finish-flag state type.
package dmem_responder_pkg;

   localparam logic [31:0] MMIO_BASE     = 32'h1000_0000;
   localparam logic [31:0] TX_DATA_OFF   = 32'h0000_0000;
   localparam logic [31:0] TX_STATUS_OFF = 32'h0000_0004;
   localparam logic [31:0] FINISH_OFF    = 32'h0000_0008;

   localparam int unsigned TXS_EMPTY_BIT = 0;
   localparam int unsigned TXS_FULL_BIT  = 1;
   localparam int unsigned TXS_OVF_BIT   = 2;
   localparam int unsigned TXS_COUNT_LSB = 8;
   localparam int unsigned TXS_COUNT_W   = 5;

   typedef enum logic {
      ST_RUNNING,
      ST_FINISHED
   } state_t;

   typedef enum logic [2:0] {
      RG_RAM,
      RG_TX_DATA,
      RG_TX_STATUS,
      RG_FINISH,
      RG_UNMAPPED
   } region_t;

   // Word-granular MMIO decode; the RAM window is decided by the caller since it depends on depth.
   function automatic region_t decode_mmio(input logic [29:0] word_addr);
      logic [31:0] byte_addr;
      byte_addr = {word_addr, 2'b00};
      if (byte_addr == MMIO_BASE + TX_DATA_OFF)
         return RG_TX_DATA;
      else if (byte_addr == MMIO_BASE + TX_STATUS_OFF)
         return RG_TX_STATUS;
      else if (byte_addr == MMIO_BASE + FINISH_OFF)
         return RG_FINISH;
      else
         return RG_UNMAPPED;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side memory bus plus the TX byte stream of the data-memory responder.
interface dmem_responder_if;
   import dmem_responder_pkg::*;

   logic [31:0] mem_addr;
   logic        mem_r_enable;
   logic        mem_w_enable;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output mem_addr, mem_r_enable, mem_w_enable, mem_wdata, tx_ready,
      input  mem_rdata, tx_data, tx_valid
   );

   modport slave (
      input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata, tx_ready,
      output mem_rdata, tx_data, tx_valid
   );

endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Synchronous FIFO for outgoing bytes; no bypass, head is always visible on dout.
module tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign dout    = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         store[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, TX byte FIFO behind MMIO, sticky finish and bus-error flags.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = 4096,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   dmem_responder_if.slave     mem,
   output logic                finished,
   output logic [31:0]         finish_code,
   output logic                bus_error
);

   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   ram [RAM_WORDS];
   logic [AW-1:0] ram_idx;
   logic          in_ram;
   logic          unused_byte_lane;
   region_t       region;
   logic          rd_en;
   logic          wr_en;
   logic [31:0]   rd_value;
   logic [31:0]   tx_status;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   state_t        state_q;
   state_t        state_d;
   logic          finish_capture;

   assign unused_byte_lane = ^mem.mem_addr[1:0];
   assign ram_idx          = mem.mem_addr[AW+1:2];
   assign in_ram           = (mem.mem_addr[31:AW+2] == '0);
   assign region           = in_ram ? RG_RAM : decode_mmio(mem.mem_addr[31:2]);

   // Requests seen while reset is high must not touch any state, RAM included.
   assign rd_en = mem.mem_r_enable & ~reset;
   assign wr_en = mem.mem_w_enable & ~reset;

   always_ff @(posedge clk) begin
      if (wr_en && region == RG_RAM)
         ram[ram_idx] <= mem.mem_wdata;
   end

   always_comb begin
      tx_status = '0;
      tx_status[TXS_EMPTY_BIT] = fifo_empty;
      tx_status[TXS_FULL_BIT]  = fifo_full;
      tx_status[TXS_OVF_BIT]   = overflow;
      tx_status[TXS_COUNT_LSB +: TXS_COUNT_W] = TXS_COUNT_W'(fifo_count);
   end

   always_comb begin
      rd_value = '0;
      unique case (region)
         RG_RAM:       rd_value = ram[ram_idx];
         RG_TX_STATUS: rd_value = tx_status;
         RG_FINISH:    rd_value = finish_code;
         default:      rd_value = '0;
      endcase
   end

   // Sampling the pre-edge RAM word gives read-before-write on a same-cycle write.
   always_ff @(posedge clk) begin
      if (reset)
         mem.mem_rdata <= '0;
      else if (rd_en)
         mem.mem_rdata <= rd_value;
   end

   assign fifo_push    = wr_en & (region == RG_TX_DATA);
   assign fifo_pop     = mem.tx_valid & mem.tx_ready;
   assign mem.tx_valid = ~fifo_empty;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (mem.mem_wdata[7:0]),
      .dout  (mem.tx_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset)
         overflow <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop)
         overflow <= 1'b1;
      else if (wr_en && region == RG_TX_STATUS && mem.mem_wdata[TXS_OVF_BIT])
         overflow <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         bus_error <= 1'b0;
      else if ((rd_en || wr_en) && region == RG_UNMAPPED)
         bus_error <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_RUNNING;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      finish_capture = 1'b0;
      unique case (state_q)
         ST_RUNNING: begin
            if (wr_en && region == RG_FINISH) begin
               finish_capture = 1'b1;
               state_d        = ST_FINISHED;
            end
         end
         ST_FINISHED: state_d = ST_FINISHED;
         default:     state_d = ST_RUNNING;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         finish_code <= '0;
      else if (finish_capture)
         finish_code <= mem.mem_wdata;
   end

   assign finished = (state_q == ST_FINISHED);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with read-data and TX-byte scoreboards.
module tb_dmem_responder;

   localparam logic [31:0] A_TXD  = 32'h1000_0000;
   localparam logic [31:0] A_TXS  = 32'h1000_0004;
   localparam logic [31:0] A_FIN  = 32'h1000_0008;
   localparam logic [31:0] A_BAD  = 32'h2000_0000;

   logic        clk;
   logic        reset;
   logic        finished;
   logic [31:0] finish_code;
   logic        bus_error;

   int n_cmp;
   int n_fail;

   logic [31:0] rd_exp [$];
   logic [7:0]  tx_exp [$];

   dmem_responder_if tif ();

   dmem_responder #(
      .RAM_WORDS  (4096),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem         (tif),
      .finished    (finished),
      .finish_code (finish_code),
      .bus_error   (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      tif.mem_addr     = addr;
      tif.mem_wdata    = data;
      tif.mem_w_enable = 1'b1;
      cycle();
      tif.mem_w_enable = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] e;
      rd_exp.push_back(exp);
      tif.mem_addr     = addr;
      tif.mem_r_enable = 1'b1;
      cycle();
      tif.mem_r_enable = 1'b0;
      e = rd_exp.pop_front();
      check(tag, tif.mem_rdata, e);
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accepted);
      if (accepted)
         tx_exp.push_back(b);
      wr(A_TXD, {24'hA5A5A5, b});
   endtask

   task automatic drain(input int budget);
      logic [7:0] e;
      tif.tx_ready = 1'b1;
      for (int c = 0; c < budget && tx_exp.size() > 0; c++) begin
         if (tif.tx_valid) begin
            e = tx_exp.pop_front();
            check("tx_byte", {24'h0, tif.tx_data}, {24'h0, e});
         end
         cycle();
      end
      tif.tx_ready = 1'b0;
      check("tx_drain_left", tx_exp.size(), 0);
      check("tx_valid_after_drain", tif.tx_valid, 1'b0);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      tif.mem_addr     = '0;
      tif.mem_wdata    = '0;
      tif.mem_r_enable = 1'b0;
      tif.mem_w_enable = 1'b0;
      tif.tx_ready     = 1'b0;

      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      check("rst_rdata", tif.mem_rdata, 32'h0);
      check("rst_tx_valid", tif.tx_valid, 1'b0);
      check("rst_finished", finished, 1'b0);
      check("rst_finish_code", finish_code, 32'h0);
      check("rst_bus_error", bus_error, 1'b0);

      // RAM write then read on the very next cycle, low address bits ignored
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      rd("ram_wr_then_rd", 32'h0000_0012, 32'hDEAD_BEEF);
      tif.mem_addr = 32'h0000_0020;
      wr(32'h0000_0020, 32'hAAAA_0001);
      cycle();
      check("rdata_hold", tif.mem_rdata, 32'hDEAD_BEEF);

      // same-cycle read and write returns the old word
      rd_exp.push_back(32'hAAAA_0001);
      tif.mem_addr     = 32'h0000_0020;
      tif.mem_wdata    = 32'hBBBB_0002;
      tif.mem_r_enable = 1'b1;
      tif.mem_w_enable = 1'b1;
      cycle();
      tif.mem_r_enable = 1'b0;
      tif.mem_w_enable = 1'b0;
      check("rw_same_cycle", tif.mem_rdata, rd_exp.pop_front());
      rd("rw_after", 32'h0000_0020, 32'hBBBB_0002);

      wr(32'h0000_3FFC, 32'h1234_5678);
      rd("ram_top_word", 32'h0000_3FFC, 32'h1234_5678);
      wr(32'h0000_0040, 32'h1111_1111);

      rd("status_empty", A_TXS, 32'h0000_0001);
      rd("txdata_read_zero", A_TXD, 32'h0);

      // overfill with sink stalled
      for (int i = 0; i < 9; i++)
         push_byte(8'(8'h41 + i), i < 8);
      check("tx_head_stalled", {24'h0, tif.tx_data}, 32'h41);
      cycle();
      check("tx_head_stable", {24'h0, tif.tx_data}, 32'h41);
      rd("status_full_ovf", A_TXS, 32'h0000_0806);
      drain(40);
      rd("status_drained_ovf", A_TXS, 32'h0000_0005);
      wr(A_TXS, 32'hFFFF_FFFB);
      rd("status_ovf_kept", A_TXS, 32'h0000_0005);
      wr(A_TXS, 32'h0000_0004);
      rd("status_ovf_clear", A_TXS, 32'h0000_0001);

      // no bypass, then push+pop while full
      push_byte(8'h60, 1'b1);
      check("no_bypass_valid", tif.tx_valid, 1'b1);
      for (int i = 1; i < 8; i++)
         push_byte(8'(8'h60 + i), 1'b1);
      rd("status_full", A_TXS, 32'h0000_0802);
      check("full_head", {24'h0, tif.tx_data}, {24'h0, tx_exp[0]});
      void'(tx_exp.pop_front());
      tif.tx_ready = 1'b1;
      push_byte(8'h68, 1'b1);
      tif.tx_ready = 1'b0;
      rd("status_full_pushpop", A_TXS, 32'h0000_0802);
      drain(40);
      rd("status_empty_again", A_TXS, 32'h0000_0001);

      // finish is sticky and keeps the first code
      check("finished_before", finished, 1'b0);
      wr(A_FIN, 32'h0000_0001);
      wr(A_FIN, 32'h0000_0007);
      check("finished", finished, 1'b1);
      check("finish_code", finish_code, 32'h0000_0001);
      rd("finish_read", A_FIN, 32'h0000_0001);

      // unmapped accesses
      check("bus_error_before", bus_error, 1'b0);
      rd("unmapped_read", A_BAD, 32'h0);
      check("bus_error_set", bus_error, 1'b1);
      wr(32'h0000_0000, 32'hCAFE_0000);
      wr(A_BAD, 32'h0000_0099);
      wr(32'h0000_4000, 32'h0000_0099);
      rd("ram_after_unmapped_wr", 32'h0000_0000, 32'hCAFE_0000);
      rd("ram_10_intact", 32'h0000_0010, 32'hDEAD_BEEF);

      // reset mid-transfer with a request presented during reset
      wr(32'h0000_0010, 32'h0000_0055);
      for (int i = 0; i < 3; i++)
         push_byte(8'(8'h70 + i), 1'b1);
      rd("pre_reset_read", 32'h0000_0010, 32'h0000_0055);
      reset            = 1'b1;
      tif.mem_addr     = 32'h0000_0040;
      tif.mem_wdata    = 32'h2222_2222;
      tif.mem_w_enable = 1'b1;
      cycle();
      reset            = 1'b0;
      tif.mem_w_enable = 1'b0;
      tx_exp.delete();
      check("rst2_tx_valid", tif.tx_valid, 1'b0);
      check("rst2_rdata", tif.mem_rdata, 32'h0);
      check("rst2_finished", finished, 1'b0);
      check("rst2_finish_code", finish_code, 32'h0);
      check("rst2_bus_error", bus_error, 1'b0);
      rd("rst2_status", A_TXS, 32'h0000_0001);
      rd("rst2_ram_kept", 32'h0000_0010, 32'h0000_0055);
      rd("rst2_req_ignored", 32'h0000_0040, 32'h1111_1111);
      push_byte(8'h5A, 1'b1);
      drain(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096: data RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO depth in bytes (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is posedge clk.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port mem_addr, input, 32: byte address from the core.
REQ-006 SHALL have port mem_r_enable, input, 1: read request, one-cycle pulse.
REQ-007 SHALL have port mem_w_enable, input, 1: write request, one-cycle pulse.
REQ-008 SHALL have port mem_wdata, input, 32: write data, full word.
REQ-009 SHALL have port mem_rdata, output, 32: registered read data.
REQ-010 SHALL have port tx_data, output, 8: FIFO head byte.
REQ-011 SHALL have port tx_valid, output, 1: FIFO non-empty.
REQ-012 SHALL have port tx_ready, input, 1: byte sink accepts head.
REQ-013 SHALL have port finished, output, 1: sticky test-finish flag.
REQ-014 SHALL have port finish_code, output, 32: value written to FINISH.
REQ-015 SHALL have port bus_error, output, 1: sticky flag, set by an access to an unmapped address.

Function
REQ-016 Address decode SHALL ignore mem_addr[1:0]; all accesses are whole words.
REQ-017 The RAM region SHALL be 0x0000_0000 up to RAM_WORDS*4-1, with word index mem_addr[log2(RAM_WORDS)+1:2].
REQ-018 The MMIO registers SHALL be: 0x1000_0000 TX_DATA, 0x1000_0004 TX_STATUS, 0x1000_0008 FINISH; every other address is unmapped.
REQ-019 Read latency SHALL be exactly 1: data for a read with mem_r_enable high in cycle N appears on mem_rdata in cycle N+1.
REQ-020 mem_rdata SHALL hold its value until the next read is accepted.
REQ-021 A RAM write with mem_w_enable high in cycle N SHALL be visible to a read issued in cycle N+1.
REQ-022 When read and write are both enabled in the same cycle, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-023 A TX_DATA write SHALL push mem_wdata[7:0]; a TX_DATA read SHALL return 0.
REQ-024 A push to a full FIFO with no pop in the same cycle SHALL be dropped and SHALL set the sticky overflow bit.
REQ-025 TX_STATUS read SHALL return bit0=empty, bit1=full, bit2=overflow, bits[12:8]=count, and 0 in all other bits.
REQ-026 A TX_STATUS write with wdata[2]=1 SHALL clear overflow; all other TX_STATUS write bits SHALL be ignored.
REQ-027 On the first FINISH write, finished SHALL become 1 and finish_code SHALL take mem_wdata; later FINISH writes SHALL be ignored until reset.
REQ-028 A FINISH read SHALL return finish_code.
REQ-029 tx_valid SHALL equal !empty, and tx_data SHALL equal the head byte.
REQ-030 A pop SHALL occur when tx_valid and tx_ready are both high; tx_data SHALL be stable while tx_valid is high and tx_ready is low.
REQ-031 A simultaneous push and pop SHALL be accepted even when full, leaving count unchanged.
REQ-032 The FIFO SHALL have no bypass: a push into an empty FIFO raises tx_valid in the next cycle.
REQ-033 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL saturate at neither bound incorrectly (range 0..FIFO_DEPTH).
REQ-034 An unmapped read SHALL return 0 and set bus_error.
REQ-035 An unmapped write SHALL have no effect other than setting bus_error.

Reset
REQ-036 Reset SHALL force, on the next clock edge: mem_rdata=0, FIFO empty (tx_valid=0), overflow=0, finished=0, finish_code=0, bus_error=0.
REQ-037 RAM contents SHALL NOT be altered by reset.
REQ-038 Reset asserted mid-transfer SHALL discard all FIFO contents.
REQ-039 Requests presented while reset is high SHALL be ignored.

Structure
REQ-040 The MMIO base address, register offsets, and TX_STATUS bit positions SHALL live in the shared package alongside state_t.
REQ-041 The FIFO SHALL be a sub-module named tx_fifo, parameterised by depth and width, with push/pop/full/empty/count ports.

Verification
REQ-042 Write 0xDEADBEEF to 0x10, then read 0x12 on the next cycle -> mem_rdata=0xDEADBEEF exactly one cycle after the read.
REQ-043 Push 9 bytes 0x41..0x49 with tx_ready=0 -> STATUS reads full=1, overflow=1, count=8; release tx_ready -> 0x41..0x48 emitted in order, then empty=1.
REQ-044 With the FIFO full, push and pop in the same cycle -> count stays 8, overflow stays 0, new byte emitted last.
REQ-045 Write FINISH 0x1 then 0x7 -> finished=1, finish_code=0x1.
REQ-046 Read 0x2000_0000 -> mem_rdata=0, bus_error=1; write to it -> RAM unchanged.
REQ-047 Reset with 3 bytes queued and RAM word 0x10=0x55 -> tx_valid=0 the next cycle, all flags 0, read of 0x10 returns 0x55.
